gsau_issue_sequencer: RTL and testbench
=======================================

GSAU_ISSUE_SEQUENCER -- requirements
Module: gsau_issue_sequencer

Interface
REQ-001 SHALL have parameter VEGGIEREGS, default 256: vector register count; REGW = $clog2(VEGGIEREGS).
REQ-002 SHALL have parameter ARR_DIM, default 4: weight rows loaded per GEMM command.
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1: GEMM command handshake.
REQ-006 SHALL have ports cmd_wbase, cmd_ibase, cmd_pbase, cmd_dbase, each input REGW: base registers for weights, inputs, partials and destinations.
REQ-007 SHALL have port cmd_nrows  input  8  input-row count, 0..255.
REQ-008 SHALL have ports iss_valid out 1, iss_ready in 1: issue handshake toward the GSAU control unit's scoreboard side.
REQ-009 SHALL have ports iss_weight out 1, iss_vsrc1 out REGW, iss_vsrc2 out REGW, iss_vdst out REGW: issued-row payload.
REQ-010 SHALL have port wb_valid  input  1  one psum row written back this cycle.
REQ-011 SHALL have ports busy out 1 (not IDLE) and done out 1 (one-cycle pulse at command completion).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD_W, STREAM, DRAIN.
REQ-013 IDLE: cmd_ready=1; a cmd_valid&&cmd_ready cycle latches all cmd fields, clears row index, and moves to LOAD_W.
REQ-014 LOAD_W: iss_valid=1, iss_weight=1, iss_vsrc1=wbase+k; k advances on each iss_valid&&iss_ready; after ARR_DIM accepted beats -> STREAM, or -> DRAIN if nrows=0.
REQ-015 STREAM: iss_valid=1, iss_weight=0, iss_vsrc1=ibase+r, iss_vsrc2=pbase+r, iss_vdst=dbase+r; r advances on accept; after nrows accepted beats -> DRAIN.
REQ-016 Register index arithmetic SHALL be modulo VEGGIEREGS (wrap, no error).
REQ-017 Payload SHALL be held stable while iss_valid=1 and iss_ready=0.
REQ-018 SHALL keep an outstanding counter (9 bits): +1 per accepted STREAM beat, -1 per wb_valid; both in one cycle -> unchanged; wb_valid at count 0 SHALL be ignored.
REQ-019 DRAIN: iss_valid=0; when counter reaches 0 -> IDLE with done=1 in the same cycle as the transition.
REQ-020 cmd_ready SHALL be 0 in every state other than IDLE; no command queueing.
REQ-021 Back-to-back commands: a command may be accepted the cycle after done.

Reset
REQ-022 On nRST low, state=IDLE, counters=0, latched fields=0, iss_valid=0, done=0, busy=0, cmd_ready=1 after release; a mid-command reset abandons it with no done pulse.

Configuration
REQ-023 Macro GSAU_SEQ_WEIGHT_REUSE_EN defined: SHALL add input cmd_reuse_w (1) and a valid bit for the last loaded wbase; accepted command with cmd_reuse_w=1 and matching wbase SHALL skip LOAD_W; reset clears the valid bit.
REQ-024 Macro undefined: no cmd_reuse_w port; every command SHALL execute LOAD_W.

Structure
REQ-025 The state enum (gsau_seq_state_t) and register-index typedef SHALL reside in sys_arr_pkg.
REQ-026 SHALL be a single flat module; no sub-module is required.

Verification
REQ-027 ARR_DIM=4, wbase=8, ibase=16, pbase=32, dbase=48, nrows=3, iss_ready=1 -> weight beats vsrc1 8,9,10,11, then rows (16,32,48),(17,33,49),(18,34,50); done after 3 wb_valid.
REQ-028 iss_ready toggling 1/0 -> no beat lost or duplicated, payload stable while stalled, same 7-beat sequence.
REQ-029 ibase=254, nrows=4 -> vsrc1 254,255,0,1.
REQ-030 nrows=0 -> 4 weight beats, then done the following cycle, no input beats.
REQ-031 wb_valid coincident with the final STREAM accept -> counter correct, done only after the last outstanding wb.
REQ-032 nRST asserted mid-STREAM -> IDLE, iss_valid=0, no done; with GSAU_SEQ_WEIGHT_REUSE_EN, a repeat wbase with cmd_reuse_w=1 -> first beat is a STREAM beat.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// -----------------------------------------------------------------------------
// sys_arr_pkg
// Shared types for the systolic-array (GSAU) command/issue path.
//   gsau_seq_state_t : issue sequencer FSM states
//   reg_idx_t        : vector register index for the default 256-entry file
//   OUTST_W          : width of the outstanding write-back counter
//   NROWS_W          : width of the per-command input-row count
// -----------------------------------------------------------------------------
package sys_arr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } gsau_seq_state_t;

  // Index into the default 256-entry vector register file.
  typedef logic [7:0] reg_idx_t;

  localparam int unsigned OUTST_W = 9;
  localparam int unsigned NROWS_W = 8;

endpackage

// File: rtl/gsau_issue_sequencer_if.sv
// -----------------------------------------------------------------------------
// gsau_issue_sequencer_if
// Command and issue channels of the GSAU issue sequencer.
//   cmd_* : GEMM command handshake plus base registers and row count
//   iss_* : per-row issue handshake and payload toward the scoreboard side
// Optional: GSAU_SEQ_WEIGHT_REUSE_EN adds cmd_reuse_w to the command channel.
// Modports:
//   master : command producer / issue consumer (control unit, testbench)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface gsau_issue_sequencer_if #(
  parameter int unsigned REGW = 8
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [REGW-1:0] cmd_wbase;
  logic [REGW-1:0] cmd_ibase;
  logic [REGW-1:0] cmd_pbase;
  logic [REGW-1:0] cmd_dbase;
  logic [7:0]      cmd_nrows;
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
  logic            cmd_reuse_w;
`endif

  logic            iss_valid;
  logic            iss_ready;
  logic            iss_weight;
  logic [REGW-1:0] iss_vsrc1;
  logic [REGW-1:0] iss_vsrc2;
  logic [REGW-1:0] iss_vdst;

`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
  modport master (
    output cmd_valid, cmd_wbase, cmd_ibase, cmd_pbase, cmd_dbase, cmd_nrows, cmd_reuse_w,
    input  cmd_ready,
    input  iss_valid, iss_weight, iss_vsrc1, iss_vsrc2, iss_vdst,
    output iss_ready
  );
  modport slave (
    input  cmd_valid, cmd_wbase, cmd_ibase, cmd_pbase, cmd_dbase, cmd_nrows, cmd_reuse_w,
    output cmd_ready,
    output iss_valid, iss_weight, iss_vsrc1, iss_vsrc2, iss_vdst,
    input  iss_ready
  );
`else
  modport master (
    output cmd_valid, cmd_wbase, cmd_ibase, cmd_pbase, cmd_dbase, cmd_nrows,
    input  cmd_ready,
    input  iss_valid, iss_weight, iss_vsrc1, iss_vsrc2, iss_vdst,
    output iss_ready
  );
  modport slave (
    input  cmd_valid, cmd_wbase, cmd_ibase, cmd_pbase, cmd_dbase, cmd_nrows,
    output cmd_ready,
    output iss_valid, iss_weight, iss_vsrc1, iss_vsrc2, iss_vdst,
    input  iss_ready
  );
`endif

endinterface

// File: rtl/gsau_issue_sequencer.sv
// -----------------------------------------------------------------------------
// gsau_issue_sequencer
// Turns one GEMM command into ARR_DIM weight-load beats followed by nrows
// input-row beats, then waits until every issued row has written back.
// Ports:
//   CLK, nRST : clock (rising edge) and asynchronous active-low reset
//   bus       : command + issue channels (gsau_issue_sequencer_if.slave)
//   wb_valid  : one partial-sum row written back this cycle
//   busy      : a command is in progress
//   done      : one-cycle pulse in the cycle the command retires
// Optional: GSAU_SEQ_WEIGHT_REUSE_EN lets a command with cmd_reuse_w=1 and
// the same wbase as the last completed weight load skip LOAD_W.
// All outputs are registered; they are computed from next-state values so
// their timing equals a state decode of the current state.
// Register-index arithmetic wraps modulo 2**REGW (VEGGIEREGS is a power of 2).
// -----------------------------------------------------------------------------
module gsau_issue_sequencer
  import sys_arr_pkg::*;
#(
  parameter int unsigned VEGGIEREGS = 256,
  parameter int unsigned ARR_DIM    = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  gsau_issue_sequencer_if.slave bus,
  input  logic                  wb_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned REGW   = $clog2(VEGGIEREGS);
  localparam int unsigned KW     = (ARR_DIM > 1) ? $clog2(ARR_DIM) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ARR_DIM - 1);

  gsau_seq_state_t      state_r, state_s;
  logic [REGW-1:0]      wbase_r, wbase_s;
  logic [REGW-1:0]      ibase_r, ibase_s;
  logic [REGW-1:0]      pbase_r, pbase_s;
  logic [REGW-1:0]      dbase_r, dbase_s;
  logic [NROWS_W-1:0]   nrows_r, nrows_s;
  logic [KW-1:0]        k_r, k_s;
  logic [NROWS_W-1:0]   row_r, row_s;
  logic [OUTST_W-1:0]   outst_r, outst_s;
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
  logic                 wld_valid_r, wld_valid_s;
  logic [REGW-1:0]      wld_base_r, wld_base_s;
`endif

  logic                 iss_valid_r, iss_valid_s;
  logic                 iss_weight_r, iss_weight_s;
  logic [REGW-1:0]      vsrc1_r, vsrc1_s;
  logic [REGW-1:0]      vsrc2_r, vsrc2_s;
  logic [REGW-1:0]      vdst_r, vdst_s;
  logic                 cmd_ready_r, cmd_ready_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;

  logic                 cmd_fire_s;
  logic                 iss_fire_s;
  logic                 inc_s;
  logic                 dec_s;

  assign cmd_fire_s = bus.cmd_valid & cmd_ready_r;
  assign iss_fire_s = iss_valid_r & bus.iss_ready;

  // Next-state, command latch, beat indices and outstanding counter.
  always_comb begin
    state_s = state_r;
    wbase_s = wbase_r;
    ibase_s = ibase_r;
    pbase_s = pbase_r;
    dbase_s = dbase_r;
    nrows_s = nrows_r;
    k_s     = k_r;
    row_s   = row_r;
    inc_s   = 1'b0;
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
    wld_valid_s = wld_valid_r;
    wld_base_s  = wld_base_r;
`endif
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          wbase_s = bus.cmd_wbase;
          ibase_s = bus.cmd_ibase;
          pbase_s = bus.cmd_pbase;
          dbase_s = bus.cmd_dbase;
          nrows_s = bus.cmd_nrows;
          k_s     = {KW{1'b0}};
          row_s   = {NROWS_W{1'b0}};
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
          if (bus.cmd_reuse_w && wld_valid_r && (bus.cmd_wbase == wld_base_r)) begin
            state_s = (bus.cmd_nrows == 8'd0) ? DRAIN : STREAM;
          end else begin
            // The array contents are about to change; forget the old load.
            wld_valid_s = 1'b0;
            state_s     = LOAD_W;
          end
`else
          state_s = LOAD_W;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_W: begin
        if (iss_fire_s) begin
          if (k_r == K_LAST) begin
            k_s     = {KW{1'b0}};
            state_s = (nrows_r == 8'd0) ? DRAIN : STREAM;
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
            wld_valid_s = 1'b1;
            wld_base_s  = wbase_r;
`endif
          end else begin
            k_s = k_r + KW'(1);
          end
        end else begin
          k_s = k_r;
        end
      end
      STREAM: begin
        if (iss_fire_s) begin
          inc_s = 1'b1;
          if (row_r == (nrows_r - 8'd1)) begin
            state_s = DRAIN;
          end else begin
            row_s = row_r + 8'd1;
          end
        end else begin
          row_s = row_r;
        end
      end
      DRAIN: begin
        if (outst_r == {OUTST_W{1'b0}}) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // A write-back with nothing outstanding is stray and ignored.
    dec_s = wb_valid & (outst_r != {OUTST_W{1'b0}});
    case ({inc_s, dec_s})
      2'b10:   outst_s = outst_r + OUTST_W'(1);
      2'b01:   outst_s = outst_r - OUTST_W'(1);
      default: outst_s = outst_r;
    endcase
  end

  // Output values for the cycle after this edge, decoded from next state.
  always_comb begin
    iss_valid_s  = 1'b0;
    iss_weight_s = 1'b0;
    vsrc1_s      = {REGW{1'b0}};
    vsrc2_s      = {REGW{1'b0}};
    vdst_s       = {REGW{1'b0}};
    case (state_s)
      LOAD_W: begin
        iss_valid_s  = 1'b1;
        iss_weight_s = 1'b1;
        vsrc1_s      = wbase_s + REGW'(k_s);
      end
      STREAM: begin
        iss_valid_s  = 1'b1;
        iss_weight_s = 1'b0;
        vsrc1_s      = ibase_s + REGW'(row_s);
        vsrc2_s      = pbase_s + REGW'(row_s);
        vdst_s       = dbase_s + REGW'(row_s);
      end
      default: begin
        iss_valid_s = 1'b0;
      end
    endcase
    cmd_ready_s = (state_s == IDLE);
    busy_s      = (state_s != IDLE);
    // done is visible in the last DRAIN cycle, the one that returns to IDLE.
    done_s      = (state_s == DRAIN) && (outst_s == {OUTST_W{1'b0}});
  end

  // State, latched command and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r      <= IDLE;
      wbase_r      <= {REGW{1'b0}};
      ibase_r      <= {REGW{1'b0}};
      pbase_r      <= {REGW{1'b0}};
      dbase_r      <= {REGW{1'b0}};
      nrows_r      <= {NROWS_W{1'b0}};
      k_r          <= {KW{1'b0}};
      row_r        <= {NROWS_W{1'b0}};
      outst_r      <= {OUTST_W{1'b0}};
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
      wld_valid_r  <= 1'b0;
      wld_base_r   <= {REGW{1'b0}};
`endif
      iss_valid_r  <= 1'b0;
      iss_weight_r <= 1'b0;
      vsrc1_r      <= {REGW{1'b0}};
      vsrc2_r      <= {REGW{1'b0}};
      vdst_r       <= {REGW{1'b0}};
      cmd_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      wbase_r      <= wbase_s;
      ibase_r      <= ibase_s;
      pbase_r      <= pbase_s;
      dbase_r      <= dbase_s;
      nrows_r      <= nrows_s;
      k_r          <= k_s;
      row_r        <= row_s;
      outst_r      <= outst_s;
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
      wld_valid_r  <= wld_valid_s;
      wld_base_r   <= wld_base_s;
`endif
      iss_valid_r  <= iss_valid_s;
      iss_weight_r <= iss_weight_s;
      vsrc1_r      <= vsrc1_s;
      vsrc2_r      <= vsrc2_s;
      vdst_r       <= vdst_s;
      cmd_ready_r  <= cmd_ready_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.iss_valid  = iss_valid_r;
  assign bus.iss_weight = iss_weight_r;
  assign bus.iss_vsrc1  = vsrc1_r;
  assign bus.iss_vsrc2  = vsrc2_r;
  assign bus.iss_vdst   = vdst_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule

// File: tb/tb_gsau_issue_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gsau_issue_sequencer
// Randomized and directed stimulus against a queue-based model of the
// sequencer: each accepted command expands into the list of beats it must
// issue; beats retire on accept, rows count as outstanding until written back.
// -----------------------------------------------------------------------------
module tb_gsau_issue_sequencer;
  import sys_arr_pkg::*;

  localparam int NREG    = 256;
  localparam int ARR_DIM = 4;

  typedef struct {
    bit w;
    int v1;
    int v2;
    int vd;
  } beat_t;

  logic CLK;
  logic nRST;
  logic wb_valid;
  logic busy;
  logic done;

  gsau_issue_sequencer_if #(.REGW(8)) bus ();

  gsau_issue_sequencer #(
    .VEGGIEREGS (NREG),
    .ARR_DIM    (ARR_DIM)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .bus      (bus),
    .wb_valid (wb_valid),
    .busy     (busy),
    .done     (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // model state
  bit       m_busy   = 1'b0;
  beat_t    m_q[$];
  int       m_outst  = 0;
  bit       m_wvalid = 1'b0;
  int       m_wbase  = 0;
  int       m_cur_wb = 0;
  int       m_wleft  = 0;

  beat_t    log_q[$];
  int       n_done_seen = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    bit skip;
    int wb;
    acc = 1'b0;
    if (!m_busy) begin
      if (bus.cmd_valid) begin
        wb   = int'(bus.cmd_wbase);
        skip = 1'b0;
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
        skip = bus.cmd_reuse_w && m_wvalid && (wb == m_wbase);
`endif
        m_busy   = 1'b1;
        m_cur_wb = wb;
        if (!skip) begin
          m_wvalid = 1'b0;
          m_wleft  = ARR_DIM;
          for (int k = 0; k < ARR_DIM; k++)
            m_q.push_back('{1'b1, (wb + k) % NREG, 0, 0});
        end
        for (int r = 0; r < int'(bus.cmd_nrows); r++)
          m_q.push_back('{1'b0, (int'(bus.cmd_ibase) + r) % NREG,
                          (int'(bus.cmd_pbase) + r) % NREG, (int'(bus.cmd_dbase) + r) % NREG});
      end
    end else if (m_q.size() != 0) begin
      if (bus.iss_ready) begin
        if (m_q[0].w) begin
          m_wleft--;
          if (m_wleft == 0) begin
            m_wvalid = 1'b1;
            m_wbase  = m_cur_wb;
          end
        end else begin
          acc = 1'b1;
        end
        void'(m_q.pop_front());
      end
    end else if (m_outst == 0) begin
      m_busy = 1'b0;
    end
    if (acc && !(wb_valid && m_outst > 0)) m_outst++;
    else if (!acc && wb_valid && m_outst > 0) m_outst--;
  endtask

  // model update at each active edge, cleared by reset
  initial begin
    forever begin
      @(posedge CLK or negedge nRST);
      if (!nRST) begin
        m_busy   = 1'b0;
        m_q.delete();
        m_outst  = 0;
        m_wvalid = 1'b0;
        m_wleft  = 0;
      end else begin
        model_step();
      end
    end
  end

  // compare process: outputs against the model every cycle
  initial begin
    int exp_valid;
    int exp_done;
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        exp_valid = (m_busy && m_q.size() != 0) ? 1 : 0;
        exp_done  = (m_busy && m_q.size() == 0 && m_outst == 0) ? 1 : 0;
        chk("cmd_ready", 32'(bus.cmd_ready), m_busy ? 0 : 1);
        chk("busy", 32'(busy), m_busy ? 1 : 0);
        chk("iss_valid", 32'(bus.iss_valid), exp_valid);
        chk("done", 32'(done), exp_done);
        if (exp_valid == 1 && bus.iss_valid) begin
          chk("iss_weight", 32'(bus.iss_weight), 32'(m_q[0].w));
          chk("iss_vsrc1", 32'(bus.iss_vsrc1), m_q[0].v1);
          if (!m_q[0].w) begin
            chk("iss_vsrc2", 32'(bus.iss_vsrc2), m_q[0].v2);
            chk("iss_vdst", 32'(bus.iss_vdst), m_q[0].vd);
          end
        end
        if (done) n_done_seen++;
        if (bus.iss_valid && bus.iss_ready)
          log_q.push_back('{bus.iss_weight, int'(bus.iss_vsrc1), int'(bus.iss_vsrc2), int'(bus.iss_vdst)});
      end
    end
  end

  task automatic drive_rw(input int rmode, input int wmode, input int cyc);
    case (rmode)
      0:       bus.iss_ready = 1'b1;
      1:       bus.iss_ready = cyc[0];
      default: bus.iss_ready = 1'($urandom_range(0, 1));
    endcase
    wb_valid = (wmode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
  endtask

  // Issue one command (caller is at posedge+1) and run it to completion.
  task automatic run_cmd(input int wb, input int ib, input int pb, input int db, input int nr,
                         input int rmode, input int wmode, input bit reuse, input bit noisy);
    int cyc;
    bit started;
    int d0;
    d0 = n_done_seen;
    log_q.delete();
    bus.cmd_wbase = 8'(wb);
    bus.cmd_ibase = 8'(ib);
    bus.cmd_pbase = 8'(pb);
    bus.cmd_dbase = 8'(db);
    bus.cmd_nrows = 8'(nr);
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
    bus.cmd_reuse_w = reuse;
`else
    if (reuse) bus.cmd_valid = 1'b1;
`endif
    bus.cmd_valid = 1'b1;
    cyc     = 0;
    started = 1'b0;
    drive_rw(rmode, wmode, cyc);
    while (cyc < 2000) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (m_busy) started = 1'b1;
      if (started && !m_busy) break;
      if (started) begin
        // command traffic while busy must be ignored
        bus.cmd_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.cmd_wbase = 8'($urandom_range(0, 255));
        bus.cmd_nrows = 8'($urandom_range(0, 255));
      end
      drive_rw(rmode, wmode, cyc);
    end
    bus.cmd_valid = 1'b0;
    bus.iss_ready = 1'b0;
    wb_valid      = 1'b0;
    if (cyc >= 2000) chk("cmd_timeout", 1, 0);
    chk("done_pulses", n_done_seen - d0, 1);
  endtask

  task automatic chk_seq(input string nm, input int sel, input int first, input int ev[$]);
    for (int i = 0; i < ev.size(); i++) begin
      int a;
      a = -1;
      if (first + i < log_q.size()) begin
        case (sel)
          1:       a = log_q[first + i].v1;
          2:       a = log_q[first + i].v2;
          default: a = log_q[first + i].vd;
        endcase
      end
      chk($sformatf("%s[%0d]", nm, i), a, ev[i]);
    end
  endtask

  initial begin
    int e[$];
    int d0;
    nRST          = 1'b0;
    wb_valid      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_wbase = 8'd0;
    bus.cmd_ibase = 8'd0;
    bus.cmd_pbase = 8'd0;
    bus.cmd_dbase = 8'd0;
    bus.cmd_nrows = 8'd0;
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
    bus.cmd_reuse_w = 1'b0;
`endif
    bus.iss_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_iss_valid", 32'(bus.iss_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk_en = 1'b1;
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // basic sequence, full-rate issue
    run_cmd(8, 16, 32, 48, 3, 0, 1, 1'b0, 1'b0);
    chk("seq_len", log_q.size(), 7);
    e = '{8, 9, 10, 11, 16, 17, 18};
    chk_seq("seq_v1", 1, 0, e);
    e = '{32, 33, 34};
    chk_seq("seq_v2", 2, 4, e);
    e = '{48, 49, 50};
    chk_seq("seq_vd", 3, 4, e);
    chk("seq_w_first", 32'(log_q[0].w), 1);

    // same command back to back with ready toggling
    run_cmd(8, 16, 32, 48, 3, 1, 1, 1'b0, 1'b0);
    chk("tog_len", log_q.size(), 7);
    e = '{8, 9, 10, 11, 16, 17, 18};
    chk_seq("tog_v1", 1, 0, e);

    // register index wrap
    run_cmd(3, 254, 253, 255, 4, 2, 1, 1'b0, 1'b0);
    e = '{254, 255, 0, 1};
    chk_seq("wrap_v1", 1, 4, e);

    // zero rows: weights only
    run_cmd(100, 1, 2, 3, 0, 0, 1, 1'b0, 1'b0);
    chk("nrows0_len", log_q.size(), 4);

    // write-back every cycle, coincident with the final accept
    run_cmd(5, 60, 70, 80, 5, 0, 0, 1'b0, 1'b0);
    chk("wbco_len", log_q.size(), 9);

    // largest row count
    run_cmd(0, 200, 100, 50, 255, 0, 1, 1'b0, 1'b0);
    chk("n255_len", log_q.size(), 259);
    e = '{198};
    chk_seq("n255_last", 1, 258, e);

    // reset in the middle of STREAM
    log_q.delete();
    d0 = n_done_seen;
    bus.cmd_wbase = 8'd8;
    bus.cmd_ibase = 8'd16;
    bus.cmd_pbase = 8'd32;
    bus.cmd_dbase = 8'd48;
    bus.cmd_nrows = 8'd10;
`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
    bus.cmd_reuse_w = 1'b0;
`endif
    bus.cmd_valid = 1'b1;
    bus.iss_ready = 1'b1;
    wb_valid      = 1'b0;
    @(posedge CLK);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(negedge CLK);
    chk("mrst_iss_valid", 32'(bus.iss_valid), 0);
    chk("mrst_busy", 32'(busy), 0);
    @(posedge CLK);
    #1;
    nRST          = 1'b1;
    bus.iss_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("mrst_no_done", n_done_seen - d0, 0);
    chk("mrst_beats", log_q.size(), 6);
    e = '{17};
    chk_seq("mrst_last", 1, 5, e);

`ifdef GSAU_SEQ_WEIGHT_REUSE_EN
    // reuse bit cleared by reset: first command loads, repeat skips LOAD_W
    run_cmd(8, 16, 32, 48, 2, 0, 1, 1'b1, 1'b0);
    chk("reuse_load_w", 32'(log_q[0].w), 1);
    run_cmd(8, 20, 32, 48, 2, 0, 1, 1'b1, 1'b0);
    chk("reuse_len", log_q.size(), 2);
    chk("reuse_first_w", 32'(log_q[0].w), 0);
    e = '{20};
    chk_seq("reuse_first_v1", 1, 0, e);
`endif

    // randomized commands
    for (int n = 0; n < 30; n++) begin
      run_cmd(($urandom_range(0, 1) == 1) ? 8 : $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 12),
              $urandom_range(0, 2), $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
